// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program image (start PC, length, words) into instruction memory,
// then releases the core from reset. Define CHECKSUM_EN to require an XOR trailer word.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  input  logic                  s_valid,
  input  logic [31:0]           s_data,
  output logic                  s_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [31:0]           start_pc,
  output logic                  proc_reset_l,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    ST_PC,
    ST_LEN,
    ST_DATA,
`ifdef CHECKSUM_EN
    ST_CSUM,
`endif
    ST_RUN,
    ST_ERR
  } state_t;

  localparam logic [32:0] C_DEPTH = 33'd1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_start_pc;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_proc_reset_l;
  logic                  r_done;
  logic                  r_error;
  logic                  w_loading;
  logic                  w_hs;
  logic                  w_len_bad;
  logic                  w_last;
`ifdef CHECKSUM_EN
  logic [31:0]           r_csum;
`endif

`ifdef CHECKSUM_EN
  assign w_loading = (r_state == ST_PC) | (r_state == ST_LEN) |
                     (r_state == ST_DATA) | (r_state == ST_CSUM);
`else
  assign w_loading = (r_state == ST_PC) | (r_state == ST_LEN) | (r_state == ST_DATA);
`endif

  assign s_ready    = w_loading & ~restart;
  assign w_hs       = s_valid & s_ready;
  assign w_len_bad  = (s_data == 32'd0) | ({1'b0, s_data} > C_DEPTH);
  assign w_last     = ({1'b0, r_cnt} == (r_len - (ADDR_WIDTH+1)'(1)));

  // Address wraps modulo the memory depth; the core sees the same wrap on fetch.
  assign imem_we    = (r_state == ST_DATA) & w_hs;
  assign imem_addr  = r_start_pc[ADDR_WIDTH+1:2] + r_cnt;
  assign imem_wdata = s_data;

  assign start_pc     = r_start_pc;
  assign proc_reset_l = r_proc_reset_l;
  assign done         = r_done;
  assign error        = r_error;

  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = ST_PC;
    end else if (w_hs) begin
      case (r_state)
        ST_PC:   w_state_nxt = (s_data[1:0] != 2'b00) ? ST_ERR : ST_LEN;
        ST_LEN:  w_state_nxt = w_len_bad ? ST_ERR : ST_DATA;
        ST_DATA: begin
          if (w_last) begin
`ifdef CHECKSUM_EN
            w_state_nxt = ST_CSUM;
`else
            w_state_nxt = ST_RUN;
`endif
          end
        end
`ifdef CHECKSUM_EN
        ST_CSUM: w_state_nxt = (s_data == r_csum) ? ST_RUN : ST_ERR;
`endif
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state        <= ST_PC;
      r_start_pc     <= '0;
      r_len          <= '0;
      r_cnt          <= '0;
      r_proc_reset_l <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
`ifdef CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      // Status flags track the state being entered so they change on the entering edge.
      r_proc_reset_l <= (w_state_nxt == ST_RUN);
      r_done         <= (w_state_nxt == ST_RUN);
      r_error        <= (w_state_nxt == ST_ERR);
      if (restart) begin
        r_cnt <= '0;
      end else if (w_hs) begin
        case (r_state)
          ST_PC:   r_start_pc <= s_data;
          ST_LEN: begin
            r_len  <= s_data[ADDR_WIDTH:0];
            r_cnt  <= '0;
`ifdef CHECKSUM_EN
            r_csum <= '0;
`endif
          end
          ST_DATA: begin
            r_cnt  <= r_cnt + ADDR_WIDTH'(1);
`ifdef CHECKSUM_EN
            r_csum <= r_csum ^ s_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
